// File: rtl/adbg_crc_seq.sv
// adbg_crc_seq: sequencer for the debug unit's 1-bit serial CRC-32 engine.
// It clears the engine, feeds the data bits of a burst, then either checks the
// received CRC bits (write burst) or shifts the CRC out toward TDO (read burst).
// Optional sticky error flag enabled by defining ADBG_CRC_SEQ_STICKY_ERR_EN.
module adbg_crc_seq #(
    parameter int WORD_BITS = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] word_count,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             crc_clr,
    output logic             crc_en,
    output logic             crc_shift,
    output logic             crc_data,
    input  logic             crc_serial_in,
    output logic             tdo_crc,
    output logic             tdo_sel,
    output logic             word_done,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             err_sticky,
    input  logic             err_clr
);
    localparam int               BIT_W    = $clog2(WORD_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

    state_t           state_reg, state_next;
    logic             mode_reg, mode_next;
    logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [4:0]       crc_cnt_reg, crc_cnt_next;
    logic             err_reg, err_next;
    logic             word_done_reg, word_done_next;
    logic             crc_ok_reg, crc_ok_next;
    logic             burst_end;    // burst completes this cycle (DONE, not aborted)

    // State and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 1'b0;
            word_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            crc_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            word_done_reg <= 1'b0;
            crc_ok_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            word_cnt_reg  <= word_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            crc_cnt_reg   <= crc_cnt_next;
            err_reg       <= err_next;
            word_done_reg <= word_done_next;
            crc_ok_reg    <= crc_ok_next;
        end
    end

    // Next-state logic and zero-latency engine controls; abort overrides everything
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        word_cnt_next  = word_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        crc_cnt_next   = crc_cnt_reg;
        err_next       = err_reg;
        word_done_next = 1'b0;
        crc_ok_next    = crc_ok_reg;
        burst_end      = 1'b0;
        crc_clr        = 1'b0;
        crc_en         = 1'b0;
        crc_shift      = 1'b0;
        crc_data       = 1'b0;
        done           = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        crc_clr       = 1'b1;
                        mode_next     = mode;
                        word_cnt_next = word_count;
                        bit_cnt_next  = '0;
                        crc_cnt_next  = '0;
                        err_next      = 1'b0;
                        state_next    = (word_count == '0) ? S_CRC : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_valid) begin
                        crc_en   = 1'b1;
                        crc_data = bit_in;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next   = '0;
                            word_done_next = 1'b1;
                            word_cnt_next  = word_cnt_reg - CNT_W'(1);
                            // Compare against 1 so the full 2^CNT_W-1 count works
                            if (word_cnt_reg == CNT_W'(1)) begin
                                state_next   = S_CRC;
                                crc_cnt_next = '0;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
                S_CRC: begin
                    if (bit_valid) begin
                        crc_shift = 1'b1;
                        if (!mode_reg && (bit_in != crc_serial_in))
                            err_next = 1'b1;
                        crc_cnt_next = crc_cnt_reg + 5'd1;
                        if (crc_cnt_reg == 5'd31)
                            state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    done        = 1'b1;
                    burst_end   = 1'b1;
                    crc_ok_next = mode_reg | ~err_reg;
                    state_next  = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign tdo_sel   = (state_reg == S_CRC) && mode_reg;
    assign tdo_crc   = tdo_sel & crc_serial_in;
    assign word_done = word_done_reg;
    assign crc_ok    = crc_ok_reg;

`ifdef ADBG_CRC_SEQ_STICKY_ERR_EN
    logic err_sticky_reg;

    // Sticky error: set by a failing check burst (wins over clear), cleared by err_clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_sticky_reg <= 1'b0;
        else if (burst_end && !mode_reg && err_reg)
            err_sticky_reg <= 1'b1;
        else if (err_clr)
            err_sticky_reg <= 1'b0;
    end

    assign err_sticky = err_sticky_reg;
`else
    logic unused_err_clr;
    logic unused_burst_end;
    assign unused_err_clr   = err_clr;
    assign unused_burst_end = burst_end;
    assign err_sticky       = 1'b0;
`endif

endmodule

// File: doc/adbg_crc_seq.md
Name: adbg_crc_seq

Overview:
- Sequencer for the debug unit's 1-bit serial CRC-32 engine during burst transfers.
- Burst write (check mode): clears the engine, feeds N words of data bits into it, then compares the 32 received CRC bits against the engine's serial output.
- Burst read (gen mode): feeds data bits, then shifts the computed CRC out toward TDO.
- Sits between the burst-transfer FSM and the CRC engine. It owns the engine's clr/enable/shift controls exclusively.

Parameters:
- WORD_BITS, 32, data bits per word; legal values 8, 16, 32, 64.
- CNT_W, 16, width of the word-count input and the internal word counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-low
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE
- mode  in  1  0 = check (write burst), 1 = gen (read burst); latched at start
- word_count  in  CNT_W  number of data words in the burst; latched at start
- abort  in  1  synchronous cancel; returns the FSM to IDLE
- bit_valid  in  1  one-cycle strobe: one serial bit shifted this cycle
- bit_in  in  1  serial data/CRC bit, valid with bit_valid
- crc_clr  out  1  to CRC engine clr
- crc_en  out  1  to CRC engine enable
- crc_shift  out  1  to CRC engine shift
- crc_data  out  1  to CRC engine data
- crc_serial_in  in  1  from CRC engine serial_out (LSB of running CRC)
- tdo_crc  out  1  CRC bit to drive onto TDO in gen mode
- tdo_sel  out  1  1 while tdo_crc must be selected onto TDO
- word_done  out  1  one-cycle pulse after the last bit of each data word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on burst completion
- crc_ok  out  1  result of the last completed burst; held until the next start
- err_sticky  out  1  sticky mismatch flag (optional feature, see below)
- err_clr  in  1  clears err_sticky (optional feature, see below)

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; mode and err internal registers 0.
- States and transitions:
  - IDLE: on start (abort low), assert crc_clr for that same cycle combinationally, latch mode and word_count, clear bit_cnt and err.
    - If word_count == 0, go to CRC.
    - Otherwise go to DATA.
  - DATA: on each bit_valid:
    - crc_en = 1 and crc_data = bit_in, same cycle (zero latency).
    - bit_cnt increments; when bit_cnt == WORD_BITS-1 it wraps to 0, word_done pulses the next cycle, and the word counter decrements.
    - The last bit of the last word moves the FSM to CRC with crc_cnt = 0.
    - Cycles without bit_valid: hold state, all engine controls 0.
  - CRC: 32 bit_valid strobes are consumed; each one asserts crc_shift = 1 (crc_en = 0).
    - Check mode: a bit_in != crc_serial_in mismatch sets err.
    - Gen mode: tdo_crc = crc_serial_in combinationally and tdo_sel = 1 for the whole state.
    - After the 32nd strobe, go to DONE.
  - DONE: done = 1 for one cycle; crc_ok = ~err in check mode, 1 in gen mode; then go to IDLE.
- Precedence rules:
  - start while busy is ignored.
  - abort in any state: next state IDLE, no done, crc_ok unchanged, engine controls 0 in the abort cycle.
  - abort together with start in IDLE: abort wins; no crc_clr.
- Engine control exclusivity: crc_en and crc_shift are never high together; crc_clr is never high together with either.
- Counters: the word counter decrements modulo 2^CNT_W and is compared to 1 to detect the last word. A word_count of 2^CNT_W-1 must complete correctly.
- Reset mid-burst: immediate return to IDLE, outputs to reset values.

Optional Feature:
- Macro: ADBG_CRC_SEQ_STICKY_ERR_EN.
- Defined:
  - err_sticky is set by any check-mode burst completing with crc_ok = 0.
  - err_sticky is cleared by err_clr.
  - Set has priority over a simultaneous err_clr.
  - err_sticky is unaffected by abort.
- Not defined: err_sticky is tied 0 and err_clr is ignored. Ports remain present.

Test Plan:
- Gen mode, WORD_BITS = 32, word_count = 2, data 32'h12345678 and 32'hDEADBEEF, then 32 strobes -> exactly 64 crc_en pulses, 2 word_done pulses, 32 crc_shift pulses; tdo_crc sequence equals the bit-reversed CRC reference model value; done pulses once; crc_ok = 1.
- Check mode with the same data and the CRC captured from the gen run fed back on bit_in -> done, crc_ok = 1, err_sticky stays 0.
- Check mode with one CRC bit flipped (bit 17) -> crc_ok = 0; err_sticky = 1 when the macro is defined; err_clr then drops it to 0.
- word_count = 0 in check mode, CRC bits all matching 32'hFFFFFFFF -> no crc_en pulses, 32 crc_shift pulses, crc_ok = 1.
- abort asserted after 40 data bits of a 3-word burst -> next cycle busy = 0, no done; a following start produces crc_clr and a correct complete burst.
- start pulsed mid-burst, and bit_valid gaps of 0-5 idle cycles -> start ignored, counts unaffected, results identical to a gap-free run.
